// File: rtl/wb_common.sv
// Shared Wishbone B3 encodings and arbiter state type.
package wb_common;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

  // Index width for a master count, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_rr_pick import wb_common::*; #(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;
  logic          found;

  assign any = |req;

  // 'last' itself is scanned last, so it only wins when nobody else asks.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: owner holds the slave for its whole cyc,
// optional watchdog terminates unanswered strobes with err.
module wb_rr_arbiter import wb_common::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0]    wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0]    wbm_dat_i,
  input  logic [NUM_MASTERS*dw/8-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]       wbm_we_i,
  input  logic [NUM_MASTERS-1:0]       wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]       wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]     wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]     wbm_bte_i,
  output logic [dw-1:0]                wbm_dat_o,
  output logic [NUM_MASTERS-1:0]       wbm_ack_o,
  output logic [NUM_MASTERS-1:0]       wbm_err_o,
  output logic [NUM_MASTERS-1:0]       wbm_rty_o,
  output logic [aw-1:0]                wbs_adr_o,
  output logic [dw-1:0]                wbs_dat_o,
  output logic [dw/8-1:0]              wbs_sel_o,
  output logic                         wbs_we_o,
  output logic                         wbs_cyc_o,
  output logic                         wbs_stb_o,
  output logic [2:0]                   wbs_cti_o,
  output logic [1:0]                   wbs_bte_o,
  input  logic [dw-1:0]                wbs_dat_i,
  input  logic                         wbs_ack_i,
  input  logic                         wbs_err_i,
  input  logic                         wbs_rty_i,
  output logic [NUM_MASTERS-1:0]       grant_o
);
  localparam int IW = idx_w(NUM_MASTERS);
  localparam int SW = dw / 8;

  arb_state_t             state, state_n;
  logic [IW-1:0]          owner, owner_n, last, last_n;
  logic [NUM_MASTERS-1:0] owner_oh, owner_oh_n;
  logic [IW-1:0]          pick_from, pick_idx;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_any;
  logic                   busy, own_cyc, raw_stb, timeout;

  assign busy    = (state == ARB_BUSY);
  assign own_cyc = busy & wbm_cyc_i[owner];
  assign raw_stb = own_cyc & wbm_stb_i[owner];

  // On release the outgoing owner is the rotation origin, giving zero-gap handover.
  assign pick_from = busy ? owner : last;

  wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req  (wbm_cyc_i),
    .last (pick_from),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      owner_oh <= '0;
      last     <= IW'(NUM_MASTERS - 1);
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      owner_oh <= owner_oh_n;
      last     <= last_n;
    end
  end

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    owner_oh_n = owner_oh;
    last_n     = last;
    case (state)
      ARB_IDLE: if (pick_any) begin
        state_n    = ARB_BUSY;
        owner_n    = pick_idx;
        owner_oh_n = pick_gnt;
      end
      ARB_BUSY: if (!wbm_cyc_i[owner]) begin
        last_n = owner;
        if (pick_any) begin
          owner_n    = pick_idx;
          owner_oh_n = pick_gnt;
        end else begin
          state_n    = ARB_IDLE;
          owner_oh_n = '0;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  assign grant_o   = owner_oh;
  assign wbm_dat_o = wbs_dat_i;
  assign wbs_cyc_o = own_cyc;
  assign wbs_stb_o = raw_stb & ~timeout;
  assign wbs_adr_o = busy ? wbm_adr_i[owner*aw +: aw] : '0;
  assign wbs_dat_o = busy ? wbm_dat_i[owner*dw +: dw] : '0;
  assign wbs_sel_o = busy ? wbm_sel_i[owner*SW +: SW] : '0;
  assign wbs_we_o  = busy & wbm_we_i[owner];
  assign wbs_cti_o = busy ? wbm_cti_i[owner*3 +: 3] : '0;
  assign wbs_bte_o = busy ? wbm_bte_i[owner*2 +: 2] : '0;

  // Gating on wbs_cyc_o drops a late ack in the cycle the owner lets go.
  always_comb begin
    wbm_ack_o        = '0;
    wbm_err_o        = '0;
    wbm_rty_o        = '0;
    wbm_ack_o[owner] = own_cyc & wbs_ack_i & ~timeout;
    wbm_err_o[owner] = (own_cyc & wbs_err_i) | timeout;
    wbm_rty_o[owner] = own_cyc & wbs_rty_i & ~timeout;
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int             WDW    = $clog2(TIMEOUT + 1);
      localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
      logic [WDW-1:0] wd_cnt;
      logic           resp;

      assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
      assign timeout = raw_stb & (wd_cnt == WD_MAX);

      // Cleared after firing so a master still holding stb gets a fresh window.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                                          wd_cnt <= '0;
        else if (!raw_stb || resp || timeout || owner_n != owner) wd_cnt <= '0;
        else if (wd_cnt != WD_MAX)                             wd_cnt <= wd_cnt + 1'b1;
      end
    end else begin : g_no_wd
      assign timeout = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed table, burst/watchdog/reset sequences, random vs reference model.
module tb_wb_rr_arbiter;
  import wb_common::*;

  localparam int N = 2, AW = 32, DW = 32, SW = 4, TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   s_rdat;
  logic            s_ack, s_err, s_rty;

  logic [DW-1:0]   mdat_o;
  logic [N-1:0]    ack, err, rty, grant;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_wdat;
  logic [SW-1:0]   s_sel;
  logic            s_we, s_cyc, s_stb;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(mdat_o), .wbm_ack_o(ack), .wbm_err_o(err), .wbm_rty_o(rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant)
  );

  typedef struct packed {
    logic [N-1:0] grant; logic cyc, stb; logic [AW-1:0] adr; logic [DW-1:0] dat;
    logic [SW-1:0] sel; logic we; logic [2:0] cti; logic [1:0] bte;
    logic [N-1:0] ack, err, rty; logic [DW-1:0] rdat;
  } obs_t;

  typedef struct {
    logic rst; logic [1:0] cyc, stb; logic sack;
    logic [1:0] grant; logic stb_o; logic [1:0] ack;
  } vec_t;

  int n_vec = 0, n_bad = 0;

  // Reference: who owns the bus, who owned it last, how long the strobe has waited.
  bit md_busy;
  int md_owner, md_last, md_wd;

  task automatic md_reset();
    md_busy = 0; md_owner = 0; md_last = N - 1; md_wd = 0;
  endtask

  function automatic int pick(input int from);
    for (int k = 1; k <= N; k++) if (m_cyc[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic obs_t model_out();
    obs_t o = '0;
    bit rs, to;
    o.rdat = s_rdat;
    if (md_busy) begin
      rs = m_cyc[md_owner] && m_stb[md_owner];
      to = rs && (md_wd == TO);
      o.grant[md_owner] = 1'b1;
      o.cyc = m_cyc[md_owner];
      o.stb = rs && !to;
      o.adr = m_adr[md_owner*AW +: AW];
      o.dat = m_dat[md_owner*DW +: DW];
      o.sel = m_sel[md_owner*SW +: SW];
      o.we  = m_we[md_owner];
      o.cti = m_cti[md_owner*3 +: 3];
      o.bte = m_bte[md_owner*2 +: 2];
      o.ack[md_owner] = o.cyc && s_ack && !to;
      o.err[md_owner] = (o.cyc && s_err) || to;
      o.rty[md_owner] = o.cyc && s_rty && !to;
    end
    return o;
  endfunction

  task automatic model_step();
    bit rs, to;
    int p;
    if (rst) begin md_reset(); return; end
    rs = md_busy && m_cyc[md_owner] && m_stb[md_owner];
    to = rs && (md_wd == TO);
    if (rs && !to && !(s_ack || s_err || s_rty)) md_wd = (md_wd < TO) ? md_wd + 1 : md_wd;
    else md_wd = 0;
    if (!md_busy) begin
      p = pick(md_last);
      if (p >= 0) begin md_owner = p; md_busy = 1; end
    end else if (!m_cyc[md_owner]) begin
      md_last = md_owner;
      p = pick(md_last);
      if (p >= 0) md_owner = p; else md_busy = 0;
    end
  endtask

  function automatic obs_t dut_out();
    obs_t o;
    o.grant = grant; o.cyc = s_cyc; o.stb = s_stb; o.adr = s_adr; o.dat = s_wdat;
    o.sel = s_sel; o.we = s_we; o.cti = s_cti; o.bte = s_bte;
    o.ack = ack; o.err = err; o.rty = rty; o.rdat = mdat_o;
    return o;
  endfunction

  task automatic settle(input string tag);
    obs_t e, a;
    #1;
    e = model_out();
    a = dut_out();
    n_vec++;
    if (e !== a) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h want %h", tag, $time, a, e);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h", tag, $time, got, want);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[m] = cyc; m_stb[m] = stb;
    m_adr[m*AW +: AW] = adr; m_dat[m*DW +: DW] = dat;
    m_cti[m*3 +: 3] = cti; m_bte[m*2 +: 2] = BTE_LINEAR;
    m_we[m] = 1'b1; m_sel[m*SW +: SW] = '1;
  endtask

  vec_t tbl[19];

  initial begin
    int acks;
    logic [2:0]  want_cti;
    logic [31:0] want_adr;
    logic        nc, quiet;
    int          r;

    tbl[0]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    tbl[3]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[4]  = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[5]  = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[6]  = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[7]  = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    tbl[8]  = '{1'b0, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
    tbl[9]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[11] = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    tbl[13] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[14] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
    tbl[15] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00};
    tbl[16] = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[17] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    tbl[18] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};

    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    md_reset();

    // Reset state
    @(negedge clk);
    settle("reset");
    chk("rst_ctl", 64'({grant, s_cyc, s_stb, s_we, s_cti, s_bte, s_sel, ack, err, rty}), 64'd0);
    chk("rst_adr", 64'(s_adr), 64'd0);
    chk("rst_dat", 64'(s_wdat), 64'd0);
    advance();
    rst = 1'b0;

    // Directed table: single write, simultaneous pairs, rotation
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst;
      if (tbl[i].rst) md_reset();
      set_m(0, tbl[i].cyc[0], tbl[i].stb[0], 32'h100, 32'hDEAD_BEEF, CTI_CLASSIC);
      set_m(1, tbl[i].cyc[1], tbl[i].stb[1], 32'h200, 32'h1234_5678, CTI_CLASSIC);
      s_ack = tbl[i].sack;
      settle("tbl_model");
      chk($sformatf("tbl%0d", i), 64'({grant, s_stb, ack}),
          64'({tbl[i].grant, tbl[i].stb_o, tbl[i].ack}));
      if (tbl[i].stb_o) begin
        want_adr = tbl[i].grant[1] ? 32'h200 : 32'h100;
        chk($sformatf("tbl%0d_adr", i), 64'(s_adr), 64'(want_adr));
        chk($sformatf("tbl%0d_dat", i), 64'(s_wdat),
            tbl[i].grant[1] ? 64'h1234_5678 : 64'hDEAD_BEEF);
      end
      advance();
    end
    rst = 1'b0;

    // M1 8-beat INC burst while M0 waits
    set_m(0, 1'b1, 1'b1, 32'h100, 32'hA5A5_0000, CTI_CLASSIC);
    set_m(1, 1'b1, 1'b1, 32'h200, 32'h0, CTI_INC);
    s_ack = 1'b0;
    settle("burst_arb");
    chk("burst_arb_gnt", 64'(grant), 64'd0);
    advance();
    acks = 0;
    for (int b = 0; b < 8; b++) begin
      want_cti = (b == 7) ? CTI_EOB : CTI_INC;
      set_m(1, 1'b1, 1'b1, 32'h200 + 32'(4 * b), 32'(b), want_cti);
      s_ack = 1'b1;
      settle("burst");
      chk("burst_gnt", 64'(grant), 64'b10);
      chk("burst_cti", 64'(s_cti), 64'(want_cti));
      chk("burst_adr", 64'(s_adr), 64'(32'h200 + 32'(4 * b)));
      if (ack == 2'b10) acks++;
      advance();
    end
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    s_ack = 1'b0;
    settle("burst_rel");
    chk("burst_acks", 64'(acks), 64'd8);
    chk("burst_rel_gnt", 64'(grant), 64'b10);
    advance();
    s_ack = 1'b1;
    settle("m0_after");
    chk("m0_after", 64'({grant, ack}), 64'({2'b01, 2'b01}));
    advance();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    s_ack = 1'b0;
    settle("idle1");
    advance();

    // Watchdog: slave silent, err one cycle at stb+16 with stb suppressed
    set_m(0, 1'b1, 1'b1, 32'h300, 32'h0, CTI_CLASSIC);
    for (int i = 0; i < 19; i++) begin
      settle("wd");
      chk($sformatf("wd_stb%0d", i), 64'(s_stb), 64'(i >= 1 && i != 17));
      chk($sformatf("wd_err%0d", i), 64'(err), (i == 17) ? 64'b01 : 64'b00);
      advance();
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    settle("idle2");
    advance();

    // Reset in the middle of an M1 burst
    set_m(1, 1'b1, 1'b1, 32'h400, 32'h0, CTI_INC);
    settle("rb_arb");
    advance();
    s_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      settle("rb_beat");
      chk("rb_gnt", 64'(grant), 64'b10);
      advance();
    end
    settle("rb_pre");
    #2;
    rst = 1'b1;
    md_reset();
    #1;
    chk("rb_async", 64'({grant, s_cyc, s_stb, ack, err, rty}), 64'd0);
    chk("rb_adr", 64'(s_adr), 64'd0);
    advance();
    rst = 1'b0;
    s_ack = 1'b0;
    set_m(0, 1'b1, 1'b1, 32'h100, 32'h0, CTI_CLASSIC);
    settle("rb_rel");
    advance();
    settle("rb_prio");
    chk("rb_prio_gnt", 64'(grant), 64'b01);
    advance();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    settle("idle3");
    advance();

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      quiet = (c >= 200 && c < 300);
      for (int m = 0; m < N; m++) begin
        nc = m_cyc[m] ? ($urandom_range(quiet ? 31 : 3) != 0) : ($urandom_range(2) == 0);
        set_m(m, nc, nc & (quiet || $urandom_range(3) != 0), $urandom, $urandom,
              3'($urandom_range(7)));
        m_we[m] = 1'($urandom);
        m_sel[m*SW +: SW] = 4'($urandom);
        m_bte[m*2 +: 2] = 2'($urandom);
      end
      r = $urandom_range(9);
      s_ack = !quiet && r < 4;
      s_err = !quiet && r == 4;
      s_rty = !quiet && r == 5;
      s_rdat = $urandom;
      rst = (c == 350);
      if (rst) md_reset();
      settle($sformatf("rand%0d", c));
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
